// File: rtl/store_data_queue_pkg.sv
// Shared store-queue types: entry lifecycle state and the record drained to memory.
package core_pkg;

   localparam int SDQ_ENTRIES = 16;
   localparam int SDQ_PTR_W   = $clog2(SDQ_ENTRIES) + 1;

   typedef enum logic [1:0] {
      SDQ_FREE      = 2'd0,
      SDQ_ALLOC     = 2'd1,
      SDQ_READY     = 2'd2,
      SDQ_COMMITTED = 2'd3
   } sdq_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      sdq_state_e  state;
   } sdq_entry_t;

endpackage

// File: rtl/store_data_queue.sv
// Circular store data queue: dispatch allocates at tail, ROB retire commits from cmt,
// committed stores drain to memory from head. Pointers carry a wrap bit for full/empty and LDQ age compare.
module store_data_queue
   import core_pkg::*;
#(
   parameter int  RETIRE_WIDTH = 2,
   localparam int PTR_W        = SDQ_PTR_W,
   localparam int IDX_W        = PTR_W - 1,
   localparam int RC_W         = $clog2(RETIRE_WIDTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_vld,
   output logic [PTR_W-1:0]  disp_sdq_marker,
   output logic [IDX_W-1:0]  disp_sdq_idx,
   output logic              disp_full,
   input  logic              exec_vld,
   input  logic [IDX_W-1:0]  exec_sdq_idx,
   input  logic [31:0]       exec_addr,
   input  logic [31:0]       exec_data,
   input  logic [1:0]        exec_size,
   input  logic [RC_W-1:0]   retire_cnt,
   input  logic              flush,
   output logic              drain_vld,
   output sdq_entry_t        drain_entry,
   input  logic              drain_rdy,
   output logic [PTR_W-1:0]  sdq_head,
   output logic              sdq_empty,
   output logic              retire_err
);

   sdq_entry_t       entries_reg  [SDQ_ENTRIES];
   sdq_entry_t       entries_next [SDQ_ENTRIES];
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] cmt_reg, cmt_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic             retire_err_reg, retire_err_next;
   logic [PTR_W-1:0] commit_ptr;
   logic             commit_stop;

   assign disp_sdq_marker = tail_reg;
   assign disp_sdq_idx    = tail_reg[IDX_W-1:0];
   assign disp_full       = (head_reg[IDX_W-1:0] == tail_reg[IDX_W-1:0]) &&
                            (head_reg[IDX_W] != tail_reg[IDX_W]);
   assign sdq_empty       = (head_reg == tail_reg);
   assign sdq_head        = head_reg;
   assign drain_entry     = entries_reg[head_reg[IDX_W-1:0]];
   assign drain_vld       = (entries_reg[head_reg[IDX_W-1:0]].state == SDQ_COMMITTED);
   assign retire_err      = retire_err_reg;

   always_comb begin
      entries_next    = entries_reg;
      head_next       = head_reg;
      tail_next       = tail_reg;
      retire_err_next = retire_err_reg;
      commit_ptr      = cmt_reg;
      commit_stop     = 1'b0;

      if (disp_vld && !disp_full && !flush) begin
         entries_next[tail_reg[IDX_W-1:0]].state = SDQ_ALLOC;
         tail_next = tail_reg + PTR_W'(1);
      end

      if (exec_vld && !flush && (entries_reg[exec_sdq_idx].state == SDQ_ALLOC)) begin
         entries_next[exec_sdq_idx].addr  = exec_addr;
         entries_next[exec_sdq_idx].data  = exec_data;
         entries_next[exec_sdq_idx].size  = exec_size;
         entries_next[exec_sdq_idx].state = SDQ_READY;
      end

      // Commit walks from cmt and halts at the first entry that has not been written.
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         if ((RC_W'(i) < retire_cnt) && !commit_stop) begin
            if (entries_reg[commit_ptr[IDX_W-1:0]].state == SDQ_READY) begin
               entries_next[commit_ptr[IDX_W-1:0]].state = SDQ_COMMITTED;
               commit_ptr = commit_ptr + PTR_W'(1);
            end else begin
               commit_stop     = 1'b1;
               retire_err_next = 1'b1;
            end
         end
      end
      cmt_next = commit_ptr;

      if (drain_vld && drain_rdy) begin
         entries_next[head_reg[IDX_W-1:0]].state = SDQ_FREE;
         head_next = head_reg + PTR_W'(1);
      end

      // Flush sees this cycle's commits, so freshly committed stores survive.
      if (flush) begin
         for (int i = 0; i < SDQ_ENTRIES; i++) begin
            if ((entries_next[i].state == SDQ_ALLOC) || (entries_next[i].state == SDQ_READY))
               entries_next[i].state = SDQ_FREE;
         end
         tail_next = commit_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SDQ_ENTRIES; i++)
            entries_reg[i] <= '0;
         head_reg       <= '0;
         cmt_reg        <= '0;
         tail_reg       <= '0;
         retire_err_reg <= 1'b0;
      end else begin
         entries_reg    <= entries_next;
         head_reg       <= head_next;
         cmt_reg        <= cmt_next;
         tail_reg       <= tail_next;
         retire_err_reg <= retire_err_next;
      end
   end

endmodule

// File: tb/tb_store_data_queue.sv
// Store data queue bench: directed scenarios plus random traffic checked each cycle
// against a sequence-number model of the queue.
module tb_store_data_queue;
   import core_pkg::*;

   localparam int ST_F = 0, ST_A = 1, ST_R = 2, ST_C = 3;

   logic        clk = 1'b0;
   logic        rst, disp_vld, disp_full, exec_vld, flush, drain_vld, drain_rdy;
   logic        sdq_empty, retire_err;
   logic [4:0]  disp_sdq_marker, sdq_head;
   logic [3:0]  disp_sdq_idx, exec_sdq_idx;
   logic [31:0] exec_addr, exec_data;
   logic [1:0]  exec_size, retire_cnt;
   sdq_entry_t  drain_entry;

   int total = 0;
   int bad   = 0;

   // Model: monotonically increasing sequence numbers, slot = seq % 16.
   int          m_head, m_cmt, m_tail;
   bit          m_err;
   int          m_st   [16];
   logic [31:0] m_addr [16];
   logic [31:0] m_data [16];
   logic [1:0]  m_size [16];

   always #5 clk = ~clk;

   store_data_queue #(.RETIRE_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .disp_vld(disp_vld), .disp_sdq_marker(disp_sdq_marker),
      .disp_sdq_idx(disp_sdq_idx), .disp_full(disp_full), .exec_vld(exec_vld),
      .exec_sdq_idx(exec_sdq_idx), .exec_addr(exec_addr), .exec_data(exec_data),
      .exec_size(exec_size), .retire_cnt(retire_cnt), .flush(flush),
      .drain_vld(drain_vld), .drain_entry(drain_entry), .drain_rdy(drain_rdy),
      .sdq_head(sdq_head), .sdq_empty(sdq_empty), .retire_err(retire_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_head = 0; m_cmt = 0; m_tail = 0; m_err = 1'b0;
      for (int k = 0; k < 16; k++) begin
         m_st[k] = ST_F; m_addr[k] = '0; m_data[k] = '0; m_size[k] = '0;
      end
   endtask

   task automatic check_outputs();
      bit exp_dv;
      exp_dv = (m_head < m_tail) && (m_st[m_head % 16] == ST_C);
      chk("marker", disp_sdq_marker, 128'(m_tail % 32));
      chk("disp_idx", disp_sdq_idx, 128'(m_tail % 16));
      chk("full", disp_full, 128'(m_tail - m_head == 16));
      chk("empty", sdq_empty, 128'(m_tail == m_head));
      chk("head", sdq_head, 128'(m_head % 32));
      chk("drain_vld", drain_vld, 128'(exp_dv));
      chk("retire_err", retire_err, 128'(m_err));
      if (exp_dv) begin
         chk("drain_data", {drain_entry.addr, drain_entry.data, drain_entry.size},
             {m_addr[m_head % 16], m_data[m_head % 16], m_size[m_head % 16]});
         chk("drain_state", drain_entry.state, SDQ_COMMITTED);
      end
   endtask

   task automatic model_update(input bit r, dv, ev, input int eidx, input logic [31:0] ea, ed,
                               input logic [1:0] es, input int rc, input bit fl, dr);
      int  os [16];
      bit  full, stop;
      if (!r) begin
         model_reset();
         return;
      end
      os   = m_st;
      full = (m_tail - m_head == 16);
      if (dv && !full && !fl) begin
         m_st[m_tail % 16] = ST_A;
         m_tail++;
      end
      if (ev && !fl && os[eidx] == ST_A) begin
         m_st[eidx] = ST_R; m_addr[eidx] = ea; m_data[eidx] = ed; m_size[eidx] = es;
      end
      stop = 1'b0;
      for (int i = 0; i < rc; i++) begin
         if (!stop) begin
            if (os[m_cmt % 16] == ST_R) begin
               m_st[m_cmt % 16] = ST_C;
               m_cmt++;
            end else begin
               stop = 1'b1; m_err = 1'b1;
            end
         end
      end
      if (dr && m_head < m_tail && os[m_head % 16] == ST_C) begin
         m_st[m_head % 16] = ST_F;
         m_head++;
      end
      if (fl) begin
         for (int k = 0; k < 16; k++)
            if (m_st[k] == ST_A || m_st[k] == ST_R) m_st[k] = ST_F;
         m_tail = m_cmt;
      end
   endtask

   // One cycle: check state left by the previous edge, drive inputs, advance model and clock.
   task automatic step(input bit r, dv, ev, input int eidx, input logic [31:0] ea, ed,
                       input logic [1:0] es, input int rc, input bit fl, dr);
      check_outputs();
      rst = r; disp_vld = dv; exec_vld = ev; exec_sdq_idx = 4'(eidx);
      exec_addr = ea; exec_data = ed; exec_size = es; retire_cnt = 2'(rc);
      flush = fl; drain_rdy = dr;
      $display("cycle rst=%0b dv=%0b ev=%0b idx=%0d addr=%h data=%h rc=%0d fl=%0b dr=%0b marker=%0h head=%0h",
               r, dv, ev, eidx, ea, ed, rc, fl, dr, disp_sdq_marker, sdq_head);
      model_update(r, dv, ev, eidx, ea, ed, es, rc, fl, dr);
      @(negedge clk);
   endtask

   task automatic do_reset();     step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_disp();      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_idle(input bit dr); step(1, 0, 0, 0, 0, 0, 0, 0, 0, dr); endtask
   task automatic do_exec(input int idx, input logic [31:0] a, d);
      step(1, 0, 1, idx, a, d, 2'd2, 0, 0, 0);
   endtask
   task automatic do_ret(input int rc, input bit fl, dr);
      step(1, 0, 0, 0, 0, 0, 0, rc, fl, dr);
   endtask

   initial begin
      rst = 1'b0; disp_vld = 1'b0; exec_vld = 1'b0; exec_sdq_idx = '0; exec_addr = '0;
      exec_data = '0; exec_size = '0; retire_cnt = '0; flush = 1'b0; drain_rdy = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);

      // Reset values and first dispatch
      chk("rst_empty", sdq_empty, 1);
      chk("rst_marker", disp_sdq_marker, 0);
      do_disp();
      chk("marker_after_disp", disp_sdq_marker, 1);
      chk("nonempty_after_disp", sdq_empty, 0);

      // Fill to 16, then an ignored 17th
      repeat (15) do_disp();
      chk("full_marker", disp_sdq_marker, 5'h10);
      chk("full_flag", disp_full, 1);
      do_disp();
      chk("ignored_disp_marker", disp_sdq_marker, 5'h10);

      // Commit everything, stall drain, then drain+dispatch together
      for (int i = 0; i < 16; i++) do_exec(i, 32'h100 + 32'(i), 32'hA000 + 32'(i));
      repeat (8) do_ret(2, 0, 0);
      repeat (3) do_idle(0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("full_cleared", disp_full, 0);
      chk("marker_held", disp_sdq_marker, 5'h10);
      do_disp();
      chk("wrap_marker", disp_sdq_marker, 5'h11);

      // Out-of-order exec, in-order drain
      do_reset();
      do_disp(); do_disp();
      do_exec(1, 32'h1000, 32'hDEAD);
      do_exec(0, 32'h2000, 32'hBEEF);
      do_ret(2, 0, 1);
      chk("drain0_data", {drain_vld, drain_entry.addr, drain_entry.data}, {1'b1, 32'h2000, 32'hBEEF});
      do_idle(1);
      chk("drain1_data", {drain_vld, drain_entry.addr, drain_entry.data}, {1'b1, 32'h1000, 32'hDEAD});
      do_idle(1);
      chk("drained_empty", sdq_empty, 1);

      // Flush after a partial retire
      do_reset();
      repeat (3) do_disp();
      for (int i = 0; i < 3; i++) do_exec(i, 32'h300 + 32'(i), 32'h5500 + 32'(i));
      do_ret(1, 1, 0);
      chk("flush_tail", disp_sdq_marker, 1);
      chk("flush_keeps_committed", drain_vld, 1);
      do_idle(1);
      chk("flush_then_empty", sdq_empty, 1);

      // Retire past a non-ready entry
      do_reset();
      do_disp(); do_disp();
      do_exec(0, 32'h40, 32'h41);
      do_ret(2, 0, 0);
      chk("retire_err_set", retire_err, 1);
      do_idle(0);
      chk("retire_err_sticky", retire_err, 1);
      chk("only_oldest_committed", drain_vld, 1);

      // Random traffic
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         bit  r, dv, ev, fl, dr;
         int  eidx, rc;
         r    = ($urandom_range(0, 299) != 0);
         dv   = ($urandom_range(0, 9) < 6);
         ev   = ($urandom_range(0, 9) < 6);
         eidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                            : (m_cmt + int'($urandom_range(0, 3))) % 16;
         rc   = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2));
         fl   = ($urandom_range(0, 39) == 0);
         dr   = ($urandom_range(0, 9) < 7);
         step(r, dv, ev, eidx, $urandom, $urandom, 2'($urandom), rc, fl, dr);
      end
      check_outputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
